// File: rtl/qs_pkg.sv
// Shared types for the queue-sort pipeline.
// Bank geometry, word/address types and the bank state record.
package qs_pkg;

    localparam int BANKS_N = 4;
    localparam int N       = 16;
    localparam int W       = 16;

    localparam int BW = $clog2(BANKS_N);
    localparam int AW = $clog2(N);
    localparam int LW = $clog2(N + 1);

    typedef logic [BW-1:0] bank_id_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [LW-1:0] len_t;
    typedef logic [W-1:0]  w_t;

    typedef enum logic [1:0] {
        BANK_IDLE      = 2'd0,
        BANK_LOADING   = 2'd1,
        BANK_SORTED    = 2'd2,
        BANK_UNLOADING = 2'd3
    } bank_status_t;

    typedef struct packed {
        bank_status_t status;
        len_t         n;
    } bank_state_t;

endpackage

// File: rtl/qs_deq_if.sv
// Output word stream of the dequeue controller (valid/ack).
// master: out_vld_r/out_data_r/out_last_r out, out_ack in; slave mirrors.
interface qs_deq_if
    import qs_pkg::*;
;
    logic out_vld_r;
    w_t   out_data_r;
    logic out_last_r;
    logic out_ack;

    modport master (
        output out_vld_r,
        output out_data_r,
        output out_last_r,
        input  out_ack
    );

    modport slave (
        input  out_vld_r,
        input  out_data_r,
        input  out_last_r,
        output out_ack
    );
endinterface

// File: rtl/qs_deq.sv
// Dequeue controller: claims sorted banks round-robin, streams words out.
// Ports: clk/rst, bank state poll/write, bank read port, deq_out stream, busy_r.
module qs_deq
    import qs_pkg::*;
#(
    parameter int OUT_FIFO_N = 8
) (
    input  logic        clk,
    input  logic        rst,
    output bank_id_t    deq_bank_idx_r,
    input  bank_state_t deq_bank_out,
    output logic        deq_bank_in_vld,
    output bank_state_t deq_bank_in,
    output logic        deq_rd_en_r,
    output addr_t       deq_rd_addr_r,
    input  logic        deq_rd_data_vld_r,
    input  w_t          deq_rd_data_r,
    qs_deq_if.master    deq_out,
    output logic        busy_r
);

    localparam int CW = $clog2(OUT_FIFO_N + 1);
    localparam int PW = $clog2(OUT_FIFO_N);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_r;
    len_t          len_r;
    len_t          iss_r;
    len_t          ret_r;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] cnt_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [W:0]    mem_r [OUT_FIFO_N];

    logic    claim;
    logic    issue;
    logic    last_iss;
    logic    credit;
    logic    push;
    logic    pop;
    logic    vld;
    len_t    issue_len;
    len_t    issue_addr;
    logic [CW:0] occ;
    logic [W:0]  head;

    assign claim = (state_r == S_WAIT) &&
                   (deq_bank_out.status == BANK_SORTED);

    // First read goes out in the claim cycle so data lands at C+3.
    assign issue_len  = claim ? deq_bank_out.n : len_r;
    assign issue_addr = claim ? '0 : iss_r;
    assign last_iss   = issue_addr == issue_len - len_t'(1);

    // Credits: every issued read owns a FIFO slot until it is popped.
    assign occ    = {1'b0, cnt_r} + {1'b0, inflight_r};
    assign credit = occ < (CW+1)'(OUT_FIFO_N);
    assign issue  = claim ? (deq_bank_out.n != '0)
                          : (state_r == S_READ) && credit;

    assign push = deq_rd_data_vld_r && (inflight_r != '0);
    assign vld  = cnt_r != '0;
    assign pop  = vld && deq_out.out_ack;
    assign head = mem_r[rd_ptr_r];

    assign deq_out.out_vld_r  = vld;
    assign deq_out.out_data_r = head[W-1:0];
    assign deq_out.out_last_r = head[W] & vld;

    assign deq_bank_in_vld = claim || (state_r == S_DONE);

    always_comb begin
        deq_bank_in = '{status: BANK_IDLE, n: '0};
        if (claim)
            deq_bank_in = '{status: BANK_UNLOADING,
                            n: deq_bank_out.n};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= S_WAIT;
            deq_bank_idx_r <= '0;
            deq_rd_en_r    <= 1'b0;
            deq_rd_addr_r  <= '0;
            busy_r         <= 1'b0;
            len_r          <= '0;
            iss_r          <= '0;
            ret_r          <= '0;
            inflight_r     <= '0;
        end else begin
            deq_rd_en_r <= issue;
            if (issue) begin
                deq_rd_addr_r <= addr_t'(issue_addr);
                iss_r         <= issue_addr + len_t'(1);
            end

            if (issue && !push)
                inflight_r <= inflight_r + CW'(1);
            else if (push && !issue)
                inflight_r <= inflight_r - CW'(1);

            if (claim)
                ret_r <= '0;
            else if (push)
                ret_r <= ret_r + len_t'(1);

            unique case (state_r)
                S_WAIT: begin
                    if (claim) begin
                        len_r  <= deq_bank_out.n;
                        busy_r <= 1'b1;
                        if (deq_bank_out.n == '0)
                            state_r <= S_DONE;
                        else if (last_iss)
                            state_r <= S_DRAIN;
                        else
                            state_r <= S_READ;
                    end
                end
                S_READ: begin
                    if (issue && last_iss)
                        state_r <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Empty FIFO with nothing in flight means last word acked.
                    if (inflight_r == '0 && cnt_r == '0)
                        state_r <= S_DONE;
                end
                S_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= S_WAIT;
                    if (deq_bank_idx_r == bank_id_t'(BANKS_N - 1))
                        deq_bank_idx_r <= '0;
                    else
                        deq_bank_idx_r <= deq_bank_idx_r + bank_id_t'(1);
                end
                default: state_r <= S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            for (int i = 0; i < OUT_FIFO_N; i++)
                mem_r[i] <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= {ret_r == len_r - len_t'(1),
                                    deq_rd_data_r};
                if (wr_ptr_r == PW'(OUT_FIFO_N - 1))
                    wr_ptr_r <= '0;
                else
                    wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                if (rd_ptr_r == PW'(OUT_FIFO_N - 1))
                    rd_ptr_r <= '0;
                else
                    rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push && !pop)
                cnt_r <= cnt_r + CW'(1);
            else if (pop && !push)
                cnt_r <= cnt_r - CW'(1);
        end
    end

    a_stray_return: assert property (
        @(posedge clk) disable iff (!rst)
        deq_rd_data_vld_r |-> inflight_r != '0
    );

    a_len_range: assert property (
        @(posedge clk) disable iff (!rst)
        claim |-> deq_bank_out.n <= len_t'(N)
    );

endmodule

// File: tb/tb_qs_deq.sv
// Bench for qs_deq: two instances (FIFO depth 8 and 2), bank model,
// scoreboard of expected output words, vector table plus corner sequences.
module tb_qs_deq;
    import qs_pkg::*;

    typedef struct {
        w_t   data;
        logic last;
    } exp_t;

    typedef struct {
        int d;
        int bank;
        int n;
        int mode;
        int base;
        int exp_idx;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bank_id_t    idx [2];
    bank_state_t bout [2];
    logic        bin_vld [2];
    bank_state_t bin [2];
    logic        rd_en [2];
    addr_t       rd_addr [2];
    logic        dv [2];
    w_t          dd [2];
    logic        o_vld [2];
    w_t          o_data [2];
    logic        o_last [2];
    logic        ack [2];
    logic        busy [2];

    bank_state_t bank_st [2][BANKS_N];
    w_t          mem [2][BANKS_N][N];

    logic     p1 [2];
    addr_t    a1 [2];
    bank_id_t b1 [2];

    int cyc = 0;
    int s_cnt [2];
    int s_last_cyc [2];
    int s_prev_cyc [2];
    bank_status_t s_last_st [2];
    bank_status_t s_prev_st [2];

    exp_t  q [2][$];
    exp_t  e;
    int    mode [2];
    int    stall [2];
    addr_t eaddr [2];
    int    rd_cnt [2];
    int    outst [2];
    int    hs [2];
    int    first_hs [2];
    int    last_hs [2];

    int checks = 0;
    int failures = 0;

    vec_t tbl [8];

    for (genvar g = 0; g < 2; g++) begin : gd
        qs_deq_if oif ();
        assign oif.out_ack = ack[g];
        assign o_vld[g]    = oif.out_vld_r;
        assign o_data[g]   = oif.out_data_r;
        assign o_last[g]   = oif.out_last_r;
        assign bout[g]     = bank_st[g][idx[g]];

        qs_deq #(.OUT_FIFO_N(g == 0 ? 8 : 2)) u_dut (
            .clk               (clk),
            .rst               (rst),
            .deq_bank_idx_r    (idx[g]),
            .deq_bank_out      (bout[g]),
            .deq_bank_in_vld   (bin_vld[g]),
            .deq_bank_in       (bin[g]),
            .deq_rd_en_r       (rd_en[g]),
            .deq_rd_addr_r     (rd_addr[g]),
            .deq_rd_data_vld_r (dv[g]),
            .deq_rd_data_r     (dd[g]),
            .deq_out           (oif),
            .busy_r            (busy[g])
        );
    end

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Bank array model: state writes and 2-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                p1[d] <= 1'b0;
                dv[d] <= 1'b0;
            end else begin
                p1[d] <= rd_en[d];
                a1[d] <= rd_addr[d];
                b1[d] <= idx[d];
                dv[d] <= p1[d];
                dd[d] <= mem[d][b1[d]][a1[d]];
                if (bin_vld[d]) begin
                    bank_st[d][idx[d]] <= bin[d];
                    s_cnt[d]      <= s_cnt[d] + 1;
                    s_prev_cyc[d] <= s_last_cyc[d];
                    s_prev_st[d]  <= s_last_st[d];
                    s_last_cyc[d] <= cyc;
                    s_last_st[d]  <= bin[d].status;
                end
            end
        end
    end

    // Ack driver, read-order/credit checks and scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                case (mode[d])
                    0: ack[d] = 1'b1;
                    1: begin
                        if (stall[d] < 20) begin
                            ack[d] = 1'b0;
                            stall[d]++;
                        end else begin
                            ack[d] = 1'b1;
                        end
                    end
                    2: ack[d] = !ack[d];
                    default: ack[d] = 1'b0;
                endcase
                if (rd_en[d]) begin
                    chk("rd_addr", rd_addr[d], eaddr[d]);
                    eaddr[d]++;
                    rd_cnt[d]++;
                    outst[d]++;
                end
                if (outst[d] != 0)
                    chk("credit", outst[d] <= (d == 0 ? 8 : 2), 1);
                if (o_vld[d] && ack[d]) begin
                    if (q[d].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out dut=%0d got=%0d want=none",
                                 d, o_data[d]);
                    end else begin
                        e = q[d].pop_front();
                        chk("out_data", o_data[d], e.data);
                        chk("out_last", o_last[d], e.last);
                    end
                    outst[d]--;
                    if (hs[d] == 0)
                        first_hs[d] = cyc;
                    last_hs[d] = cyc;
                    hs[d]++;
                end
            end
        end
    end

    task automatic start_xfer(input int d, input int bank,
                              input int n, input int m,
                              input int base);
        for (int i = 0; i < n; i++) begin
            mem[d][bank][i] = w_t'(base + 3 * i);
            q[d].push_back('{data: w_t'(base + 3 * i),
                             last: (i == n - 1)});
        end
        rd_cnt[d] = 0;
        eaddr[d]  = '0;
        hs[d]     = 0;
        stall[d]  = 0;
        mode[d]   = m;
        bank_st[d][bank] = '{status: BANK_SORTED, n: len_t'(n)};
    endtask

    task automatic wait_done(input int d, input int bank);
        int t = 0;
        while (!(bank_st[d][bank].status == BANK_IDLE &&
                 busy[d] == 1'b0 && q[d].size() == 0) && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("xfer_timeout", t < 600, 1);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        start_xfer(v.d, v.bank, v.n, v.mode, v.base);
        @(negedge clk);
        wait_done(v.d, v.bank);
        chk("bank_idx", idx[v.d], v.exp_idx);
        chk("reads", rd_cnt[v.d], v.n);
        chk("words", hs[v.d], v.n);
        chk("idle_n", bank_st[v.d][v.bank].n, 0);
        if (v.n == 0) begin
            chk("strobe_gap", s_last_cyc[v.d] - s_prev_cyc[v.d], 1);
            chk("strobe1", s_prev_st[v.d], BANK_UNLOADING);
            chk("strobe2", s_last_st[v.d], BANK_IDLE);
        end
        if (v.d == 0 && v.mode == 0 && v.n > 1)
            chk("throughput", last_hs[v.d] - first_hs[v.d], v.n - 1);
    endtask

    initial begin
        int sc;

        tbl[0] = '{d: 0, bank: 1, n: N, mode: 1, base: 100, exp_idx: 2};
        tbl[1] = '{d: 0, bank: 2, n: 0, mode: 0, base: 0,   exp_idx: 3};
        tbl[2] = '{d: 0, bank: 3, n: 7, mode: 2, base: 200, exp_idx: 0};
        tbl[3] = '{d: 1, bank: 0, n: 6, mode: 2, base: 300, exp_idx: 1};
        tbl[4] = '{d: 1, bank: 1, n: N, mode: 2, base: 400, exp_idx: 2};
        tbl[5] = '{d: 1, bank: 2, n: 1, mode: 0, base: 500, exp_idx: 3};
        tbl[6] = '{d: 1, bank: 3, n: N, mode: 1, base: 600, exp_idx: 0};
        tbl[7] = '{d: 0, bank: 0, n: N, mode: 0, base: 700, exp_idx: 1};

        for (int d = 0; d < 2; d++) begin
            ack[d] = 1'b0;
            mode[d] = 0;
            stall[d] = 0;
            outst[d] = 0;
            s_cnt[d] = 0;
            for (int b = 0; b < BANKS_N; b++) begin
                bank_st[d][b] = '{status: BANK_IDLE, n: '0};
                for (int i = 0; i < N; i++)
                    mem[d][b][i] = '0;
            end
        end

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_rd_en", rd_en[d], 0);
            chk("rst_vld", o_vld[d], 0);
            chk("rst_busy", busy[d], 0);
            chk("rst_idx", idx[d], 0);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Claim-to-output latency on bank 0: 3,5,9,12.
        mem[0][0][0] = 16'd3;
        mem[0][0][1] = 16'd5;
        mem[0][0][2] = 16'd9;
        mem[0][0][3] = 16'd12;
        q[0].push_back('{data: 16'd3,  last: 1'b0});
        q[0].push_back('{data: 16'd5,  last: 1'b0});
        q[0].push_back('{data: 16'd9,  last: 1'b0});
        q[0].push_back('{data: 16'd12, last: 1'b1});
        rd_cnt[0] = 0;
        eaddr[0]  = '0;
        hs[0]     = 0;
        bank_st[0][0] = '{status: BANK_SORTED, n: len_t'(4)};
        #1;
        chk("claim_vld", bin_vld[0], 1);
        chk("claim_st", bin[0].status, BANK_UNLOADING);
        chk("claim_n", bin[0].n, 4);
        @(negedge clk);
        chk("c1_rd_en", rd_en[0], 1);
        chk("c1_busy", busy[0], 1);
        repeat (2) @(negedge clk);
        chk("c3_vld", o_vld[0], 0);
        @(negedge clk);
        chk("c4_vld", o_vld[0], 1);
        chk("c4_data", o_data[0], 3);
        wait_done(0, 0);
        chk("lat_idx", idx[0], 1);
        chk("lat_words", hs[0], 4);
        chk("lat_span", last_hs[0] - first_hs[0], 3);

        for (int i = 0; i < 8; i++)
            run_vec(tbl[i]);

        // A LOADING bank is polled but never claimed.
        bank_st[0][1] = '{status: BANK_LOADING, n: len_t'(5)};
        sc = s_cnt[0];
        repeat (10) @(negedge clk);
        chk("loading_strobes", s_cnt[0] - sc, 0);
        chk("loading_idx", idx[0], 1);
        chk("loading_busy", busy[0], 0);

        // Reset in the middle of READ abandons the transfer.
        for (int i = 0; i < N; i++)
            mem[0][1][i] = w_t'(i);
        mode[0] = 3;
        rd_cnt[0] = 0;
        eaddr[0] = '0;
        bank_st[0][1] = '{status: BANK_SORTED, n: len_t'(N)};
        repeat (4) @(negedge clk);
        chk("mid_busy", busy[0], 1);
        rst = 1'b0;
        #1;
        chk("mr_rd_en", rd_en[0], 0);
        chk("mr_addr", rd_addr[0], 0);
        chk("mr_vld", o_vld[0], 0);
        chk("mr_data", o_data[0], 0);
        chk("mr_last", o_last[0], 0);
        chk("mr_busy", busy[0], 0);
        chk("mr_idx", idx[0], 0);
        for (int b = 0; b < BANKS_N; b++)
            bank_st[0][b] = '{status: BANK_IDLE, n: '0};
        q[0].delete();
        outst[0] = 0;
        mode[0] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_idx", idx[0], 0);
        chk("post_strobe", bin_vld[0], 0);
        chk("post_rd_en", rd_en[0], 0);
        run_vec('{d: 0, bank: 0, n: 3, mode: 0, base: 900, exp_idx: 1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
